// File: rtl/contador_pkg.sv
// Shared types and constants for the up-counter block.
// Holds the FSM state encoding and the button synchronizer depth.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } estado_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/contador_ascendente_if.sv
// Control and status bundle of the up-counter: button levels, tick/limit in, count/tc/running out.
// master drives the buttons and configuration, slave is the counter itself.
interface contador_ascendente_if #(
  parameter int N = 4
);

  logic         start;
  logic         stop;
  logic         clear;
  logic         tick;
  logic [N-1:0] limit;
  logic [N-1:0] count;
  logic         tc;
  logic         running;

  modport master (
    output start, stop, clear, tick, limit,
    input  count, tc, running
  );

  modport slave (
    input  start, stop, clear, tick, limit,
    output count, tc, running
  );

endinterface

// File: rtl/detector_flanco.sv
// Button synchronizer plus rising-edge detector: one-cycle pulse per low-to-high transition.
// Pulse is combinational from the synchronizer output, two edges after the input rises.
module detector_flanco
  import contador_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic [SYNC_DEPTH-1:0] sync;
  logic [SYNC_DEPTH-1:0] fill;
  logic                  prev;
  logic                  armed;
  logic                  sync_out;

  assign sync_out = sync[SYNC_DEPTH-1];

  // armed only once the chain holds real samples and has seen the button low,
  // so a button held through reset release never yields a pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], in};
      fill <= {fill[SYNC_DEPTH-2:0], 1'b1};
      prev <= sync_out;
      if (fill[SYNC_DEPTH-1] && !sync_out) begin
        armed <= 1'b1;
      end
    end
  end

  assign pulse = armed & sync_out & ~prev;

endmodule

// File: rtl/contador_ascendente.sv
// Wrapping up-counter 0..limit with start/stop/clear buttons and IDLE/RUN/PAUSE control.
// Button effects appear two edges after the synchronizer samples them; tick acts on the next edge.
module contador_ascendente
  import contador_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  contador_ascendente_if.slave  bus
);

  estado_t      state;
  estado_t      state_next;
  logic         start_p;
  logic         stop_p;
  logic         clear_p;
  logic [N-1:0] count_q;
  logic [N-1:0] count_next;
  logic         tc_q;
  logic         tc_next;
  logic         running_q;

  detector_flanco u_start (
    .clk   (clk),
    .reset (reset),
    .in    (bus.start),
    .pulse (start_p)
  );

  detector_flanco u_stop (
    .clk   (clk),
    .reset (reset),
    .in    (bus.stop),
    .pulse (stop_p)
  );

  detector_flanco u_clear (
    .clk   (clk),
    .reset (reset),
    .in    (bus.clear),
    .pulse (clear_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      running_q <= 1'b0;
    end else begin
      state     <= state_next;
      running_q <= (state_next == RUN);
    end
  end

  // clear freezes the state so it also wins over PAUSE->IDLE; stop beats start
  always_comb begin
    state_next = state;
    if (!clear_p) begin
      case (state)
        IDLE:    if (start_p && !stop_p) state_next = RUN;
        RUN:     if (stop_p) state_next = PAUSE;
        PAUSE: begin
          if (stop_p) begin
            state_next = IDLE;
          end else if (start_p) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count_q;
    tc_next    = 1'b0;
    if (clear_p) begin
      count_next = '0;
    end else if (state == PAUSE && stop_p) begin
      count_next = '0;
    end else if (state == RUN && bus.tick) begin
      // >= so a limit lowered under the current count wraps on the next tick
      if (count_q >= bus.limit) begin
        count_next = '0;
        tc_next    = 1'b1;
      end else begin
        count_next = count_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_next;
      tc_q    <= tc_next;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = running_q;

endmodule

// File: doc/contador_ascendente.md
CONTADOR_ASCENDENTE -- requirements
Module: contador_ascendente

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the rising-edge system clock.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, an asynchronous button level that requests counting.
REQ-005 The block SHALL have port stop, input, 1 bit, an asynchronous button level that requests pause, or return to idle when already paused.
REQ-006 The block SHALL have port clear, input, 1 bit, an asynchronous button level that requests count zeroing.
REQ-007 The block SHALL have port tick, input, 1 bit, a synchronous count-enable strobe.
REQ-008 The block SHALL have port limit, input, N bits, the wrap value: count runs 0..limit.
REQ-009 The block SHALL have port count, output, N bits, the current count.
REQ-010 The block SHALL have port tc, output, 1 bit, a terminal-count pulse.
REQ-011 The block SHALL have port running, output, 1 bit, which is high while in state RUN.

Function
REQ-012 start, stop and clear SHALL each pass through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle internal pulse per low-to-high transition.
REQ-013 An input rising before clk edge k, with setup met, SHALL have its effect visible on the outputs after edge k+2.
REQ-014 The FSM SHALL have the states IDLE, RUN and PAUSE.
REQ-015 FSM transitions SHALL be: IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; PAUSE -stop-> IDLE.
REQ-016 Any other pulse/state combination SHALL leave the state unchanged.
REQ-017 On the PAUSE -> IDLE transition, count SHALL be set to 0.
REQ-018 If the start and stop pulses coincide, stop SHALL win.
REQ-019 In RUN with tick=1, count SHALL become 0 if count >= limit; otherwise it SHALL become count+1.
REQ-020 The count SHALL be modulo-2^N, with no carry out.
REQ-021 With tick=0, or in IDLE/PAUSE, count SHALL hold its value.
REQ-022 tc SHALL be registered and high for exactly the one cycle in which count has just wrapped to 0 by the rule in REQ-019.
REQ-023 tc SHALL be 0 in all other cycles.
REQ-024 With limit=0, count SHALL stay 0 and tc SHALL pulse on every tick in RUN.
REQ-025 If limit is lowered below the current count, the next tick in RUN SHALL wrap count to 0 and assert tc.
REQ-026 A clear pulse SHALL set count to 0 in any state, without changing state, and SHALL suppress tc that cycle.
REQ-027 clear SHALL take priority over tick and over the PAUSE -> IDLE transition.
REQ-028 running SHALL be a registered decode of state == RUN, updating on the same edge as the state.

Reset
REQ-029 With reset=0, asynchronously, the block SHALL set count=0, tc=0, running=0 and state=IDLE, and clear all synchronizer and edge-detector flops to 0.
REQ-030 A button held high through reset release SHALL NOT produce a pulse.
REQ-031 Reset asserted mid-count SHALL abort immediately.
REQ-032 After reset release, the first tick SHALL NOT count until a start pulse is seen.

Structure
REQ-033 Package contador_pkg SHALL hold the state enum type (IDLE, RUN, PAUSE) and the synchronizer depth constant (2).
REQ-034 Sub-module detector_flanco SHALL implement one 2-flop synchronizer plus a rising-edge detector, with ports clk, reset, in and pulse.
REQ-035 detector_flanco SHALL be instantiated three times, once each for start, stop and clear.
REQ-036 The counter and FSM SHALL reside in contador_ascendente.

Verification
REQ-037 Scenario "reset release": reset 0 -> 1 with start held high -> count=0, running=0, no state change for 10 cycles.
REQ-038 Scenario "basic wrap": N=4, limit=9, start, tick every cycle -> count 0,1,...,9,0; tc high only in the cycle count=0 after 9; period 10 cycles.
REQ-039 Scenario "pause/resume/idle": with count=5, stop -> running=0, count held at 5; start -> counting resumes from 6 on the next tick; stop twice -> IDLE, count=0.
REQ-040 Scenario "priority": start and stop rise in the same cycle in IDLE -> remains IDLE; clear coincident with a wrap tick at count=limit=3 -> count=0, tc=0.
REQ-041 Scenario "limit edge": limit=0 -> tc on every tick, count=0; then limit changed 15 -> 2 with count=12 -> next tick gives count=0, tc=1.
REQ-042 Scenario "async reset mid-run": reset pulled low between clock edges at count=7 -> count=0, running=0 before the next edge.
